fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the instruction decoder.
- Owns the program counter and issues word fetches to instruction memory over a req/ack handshake.
- Buffers returned words in a small prefetch FIFO and presents {instruction, pc} to the decoder under valid/ready.
- Handles branch redirects by flushing the FIFO and discarding any fetch still in flight.

Parameters:
- ADDR_W, 32, address and PC width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- DEPTH, 2, prefetch FIFO entries; power of two, ≥ 2.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  reset; asynchronous, active-low.
- imem_req  out  1  fetch request; held until imem_ack.
- imem_addr  out  ADDR_W  fetch address, word-aligned; stable while imem_req=1.
- imem_ack  in  1  memory response; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  fetched instruction word.
- instr_valid  out  1  FIFO head is valid.
- instr_ready  in  1  decoder accepts the head this cycle.
- instruction  out  32  head instruction word; drives the decoder's instruction input.
- instr_pc  out  ADDR_W  address of the head instruction.
- pc_plus8  out  ADDR_W  instr_pc+8, the architectural r15 read value.
- redirect  in  1  branch/PC write taken; single-cycle pulse.
- redirect_pc  in  ADDR_W  new PC; bits [1:0] are forced to 0.

Behaviour:
- Reset, asynchronous while rst_n=0:
  - pc=RESET_PC, FIFO empty, state=REQ.
  - instr_valid=0, instruction=0, instr_pc=0.
  - imem_req=0 while rst_n=0; imem_req=1 in the first cycle after release, with imem_addr=RESET_PC.
- imem_req and imem_addr are decoded from registered state only; there is no combinational path from imem_ack.
- States:
  - IDLE: no request. Go to REQ when count<DEPTH (count after this cycle's pop).
  - REQ: imem_req=1, imem_addr=pc.
    - On imem_ack without redirect: push {imem_rdata, pc}, pc+=4.
    - After that push: stay in REQ if space remains, else go to IDLE.
    - On redirect without ack: go to DROP. The address stays stable because the bus cannot abort a request.
  - DROP: imem_req=1 with the old address. On imem_ack, discard the data and go to REQ.
- Only one fetch is outstanding at a time.
- Back-to-back acks are allowed: one word per cycle while in REQ.
- Redirect, in any state:
  - The FIFO is flushed, so instr_valid=0 next cycle.
  - pc=redirect_pc&~3.
  - Redirect in the same cycle as imem_ack: the acked word is discarded and state=REQ at the new PC.
  - Redirect in IDLE: go to REQ.
  - Redirect in DROP: stay in DROP and update pc to the latest redirect_pc.
- Latency: imem_ack in cycle N puts the word on instruction with instr_valid=1 in cycle N+1 (FIFO was empty, no redirect).
- FIFO:
  - Pop on instr_valid&instr_ready.
  - Push and pop in the same cycle are allowed, including when full: a pop frees space, so the REQ→IDLE decision uses post-pop count.
  - Pointers wrap modulo DEPTH; count width is clog2(DEPTH)+1.
  - Push when full cannot occur by construction; assert on it in simulation.
- PC arithmetic: pc+4 and pc_plus8 wrap modulo 2^ADDR_W (32'hFFFF_FFFC+4 → 0).
- Head outputs hold stable while instr_valid=1 and instr_ready=0.
- Reset asserted mid-request: everything clears at once and imem_req drops asynchronously. Memory must tolerate the abandoned request.

Decomposition:
- Shared package holds:
  - fetch-state enum {IDLE, REQ, DROP}.
  - WORD_BYTES=4.
  - PC_READ_OFFSET=8.
  - ARM_NOP=32'hE1A0_0000 (bench filler).
- One sub-module, fetch_fifo (DEPTH×(32+ADDR_W), push/pop/flush, full/empty/count), instantiated once.

Test Plan:
- Reset release, memory acks every cycle with word=addr|32'hE000_0000, ready=1 → imem_addr 0,4,8,…; instr_pc tracks; pc_plus8=instr_pc+8; one instruction per cycle after 2-cycle fill.
- instr_ready=0 for 5 cycles → exactly 2 words buffered, imem_req=0 (IDLE); ready=1 → heads at 0x0, 0x4, then fetch resumes at 0x8.
- Redirect to 32'h0000_0103 while a fetch of 0x8 is pending with ack 3 cycles later → FIFO flushed; DROP holds addr 0x8; acked word never valid; next req addr 0x100.
- Redirect in the same cycle as imem_ack → acked word dropped; next imem_addr=redirect_pc; instr_valid=0 the following cycle.
- RESET_PC=32'hFFFF_FFF8, continuous acks → fetches FFFF_FFF8, FFFF_FFFC, 0000_0000; pc_plus8 at FFFF_FFFC = 0000_0004.
- rst_n pulled low mid-REQ with FIFO holding 1 entry → imem_req=0 and instr_valid=0 immediately; after release first fetch at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   fetch_state_e  : fetch sequencer states
//   WORD_BYTES     : PC increment per fetched word
//   PC_READ_OFFSET : offset from instr_pc to the architectural r15 read value
//   ARM_NOP        : filler word (mov r0, r0)
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  localparam int unsigned WORD_BYTES     = 4;
  localparam int unsigned PC_READ_OFFSET = 8;
  localparam logic [31:0] ARM_NOP        = 32'hE1A0_0000;

endpackage

// File: rtl/fetch_unit_fifo.sv
// Prefetch FIFO for the fetch stage (module fetch_fifo).
//   clk, rst_n  : clock, async active-low reset
//   push        : write push_data at the tail
//   pop         : drop the head (ignored when empty)
//   flush       : empty the FIFO; wins over push and pop
//   head_data   : head entry, zero while empty
//   full, empty : occupancy flags
//   count       : number of valid entries
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  input  logic                    flush,
  output logic [WIDTH-1:0]        head_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign count     = count_q;
  assign head_data = empty ? '0 : mem_q[rd_ptr_q];
  assign do_pop    = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // The fetch sequencer never requests without guaranteed space.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !do_pop && !flush));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/ack bus,
// buffers them in a prefetch FIFO and hands {instruction, pc} to decode.
//   clk, rst_n            : clock, async active-low reset
//   imem_req/imem_addr    : fetch request and word address (registered)
//   imem_ack/imem_rdata   : memory response, data valid with ack
//   instr_valid/ready     : decoder handshake on the FIFO head
//   instruction, instr_pc : head word and its address
//   pc_plus8              : instr_pc + 8 (r15 read value)
//   redirect/redirect_pc  : branch redirect pulse and target
//
// state | meaning
// IDLE  | FIFO full, no request on the bus
// REQ   | request at pc outstanding; acked words are pushed
// DROP  | request at a stale address outstanding; its data is discarded
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int unsigned        DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instruction,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] pc_plus8,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count, count_post;
  logic [31+ADDR_W:0] head;

  assign instr_valid = !fifo_empty;
  assign fifo_pop    = instr_valid && instr_ready;
  assign fifo_push   = (state_q == REQ) && imem_ack && !redirect;
  assign count_post  = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32 + ADDR_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data ({imem_rdata, pc_q}),
    .pop       (fifo_pop),
    .flush     (redirect),
    .head_data (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign instruction = head[31+ADDR_W:ADDR_W];
  assign instr_pc    = head[ADDR_W-1:0];
  assign pc_plus8    = instr_pc + ADDR_W'(PC_READ_OFFSET);

  // Reset gates the request directly so it drops without waiting for a clock.
  assign imem_req  = rst_n && (state_q != IDLE);
  assign imem_addr = addr_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (redirect) begin
      pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
      // A request still unanswered must complete before the new PC is used.
      if (state_q == IDLE || imem_ack) state_d = REQ;
      else                             state_d = DROP;
    end else begin
      unique case (state_q)
        IDLE: if (!fifo_full || fifo_pop) state_d = REQ;
        REQ: begin
          if (imem_ack) begin
            pc_d    = pc_q + ADDR_W'(WORD_BYTES);
            state_d = (count_post < CNT_W'(DEPTH)) ? REQ : IDLE;
          end
        end
        DROP: if (imem_ack) state_d = REQ;
        default: state_d = IDLE;
      endcase
    end
    // The bus address only follows the PC when no stale request is pending.
    addr_d = (state_d == DROP) ? addr_q : pc_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, imem_ack, instr_ready, redirect;
  logic [31:0] imem_rdata, redirect_pc;
  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, instruction, instr_pc, pc_plus8;

  logic        rst_w, ack_w, ready_w, redirect_w;
  logic [31:0] rdata_w, redirect_pc_w;
  logic        req_w, valid_w;
  logic [31:0] addr_w, instruction_w, pc_w, pc8_w;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instruction(instruction), .instr_pc(instr_pc),
    .pc_plus8(pc_plus8), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_wrap (
    .clk(clk), .rst_n(rst_w), .imem_req(req_w), .imem_addr(addr_w),
    .imem_ack(ack_w), .imem_rdata(rdata_w), .instr_valid(valid_w),
    .instr_ready(ready_w), .instruction(instruction_w), .instr_pc(pc_w),
    .pc_plus8(pc8_w), .redirect(redirect_w), .redirect_pc(redirect_pc_w)
  );

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = ARM_NOP;
    instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
    checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", instruction); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", instr_pc); end
    rst_n = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL release_req: got %b expected 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL release_addr: got %h expected 0", imem_addr); end
    checks++; if (req_w !== 1'b0) begin errors++; $display("FAIL wrap_in_reset_req: got %b expected 0", req_w); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    do_reset();
    instr_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL stream_req k=%0d: got %b expected 1", k, imem_req); end
      checks++; if (imem_addr !== 32'(4*k)) begin errors++; $display("FAIL stream_addr k=%0d: got %h expected %h", k, imem_addr, 32'(4*k)); end
      if (k == 0) begin
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stream_fill_valid: got %b expected 0", instr_valid); end
      end else begin
        exp_pc = 32'(4*(k-1));
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stream_valid k=%0d: got %b expected 1", k, instr_valid); end
        checks++; if (instr_pc !== exp_pc) begin errors++; $display("FAIL stream_pc k=%0d: got %h expected %h", k, instr_pc, exp_pc); end
        checks++; if (instruction !== (exp_pc | 32'hE000_0000)) begin errors++; $display("FAIL stream_instr k=%0d: got %h expected %h", k, instruction, exp_pc | 32'hE000_0000); end
        checks++; if (pc_plus8 !== exp_pc + 32'd8) begin errors++; $display("FAIL stream_pc8 k=%0d: got %h expected %h", k, pc_plus8, exp_pc + 32'd8); end
      end
      imem_ack = 1'b1;
      imem_rdata = 32'(4*k) | 32'hE000_0000;
      next_cycle();
    end
    imem_ack = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    instr_ready = 1'b0;
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL stall_addr0: got %h expected 0", imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'hE000_0000;
    next_cycle();
    checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL stall_addr1: got %h expected 4", imem_addr); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL stall_head1: got %h expected 0", instr_pc); end
    imem_ack = 1'b1; imem_rdata = 32'hE000_0004;
    next_cycle();
    imem_ack = 1'b0; imem_rdata = ARM_NOP;
    for (int c = 2; c < 5; c++) begin
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_idle_req c=%0d: got %b expected 0", c, imem_req); end
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stall_valid c=%0d: got %b expected 1", c, instr_valid); end
      checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL stall_hold_pc c=%0d: got %h expected 0", c, instr_pc); end
      checks++; if (instruction !== 32'hE000_0000) begin errors++; $display("FAIL stall_hold_instr c=%0d: got %h expected e0000000", c, instruction); end
      next_cycle();
    end
    instr_ready = 1'b1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req5: got %b expected 0", imem_req); end
    next_cycle();
    checks++; if (instr_pc !== 32'h4) begin errors++; $display("FAIL stall_head2: got %h expected 4", instr_pc); end
    checks++; if (instruction !== 32'hE000_0004) begin errors++; $display("FAIL stall_instr2: got %h expected e0000004", instruction); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL stall_resume_req: got %b expected 1", imem_req); end
    checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL stall_resume_addr: got %h expected 8", imem_addr); end
    next_cycle();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stall_drained: got %b expected 0", instr_valid); end
    checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL stall_addr_held: got %h expected 8", imem_addr); end
  endtask

  task automatic test_redirect_drop();
    do_reset();
    instr_ready = 1'b1;
    imem_ack = 1'b1; imem_rdata = 32'hE000_0000;
    next_cycle();
    imem_ack = 1'b1; imem_rdata = 32'hE000_0004;
    next_cycle();
    checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL drop_pending_addr: got %h expected 8", imem_addr); end
    checks++; if (instr_pc !== 32'h4) begin errors++; $display("FAIL drop_pre_head: got %h expected 4", instr_pc); end
    imem_ack = 1'b0; imem_rdata = ARM_NOP;
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    next_cycle();
    redirect = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL drop_flushed c=%0d: got %b expected 0", c, instr_valid); end
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL drop_req c=%0d: got %b expected 1", c, imem_req); end
      checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL drop_addr c=%0d: got %h expected 8", c, imem_addr); end
      if (c == 2) begin imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; end
      next_cycle();
    end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL drop_discard: got %b expected 0", instr_valid); end
    checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL drop_new_addr: got %h expected 100", imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'hE000_0100;
    next_cycle();
    imem_ack = 1'b0;
    checks++; if (instr_pc !== 32'h100) begin errors++; $display("FAIL drop_target_pc: got %h expected 100", instr_pc); end
    checks++; if (instruction !== 32'hE000_0100) begin errors++; $display("FAIL drop_target_instr: got %h expected e0000100", instruction); end
    checks++; if (imem_addr !== 32'h104) begin errors++; $display("FAIL drop_next_addr: got %h expected 104", imem_addr); end
  endtask

  task automatic test_redirect_ack();
    do_reset();
    instr_ready = 1'b1;
    imem_ack = 1'b1; imem_rdata = 32'hE000_0000;
    next_cycle();
    checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL rack_addr: got %h expected 4", imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'hE000_0004;
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    next_cycle();
    redirect = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rack_flushed: got %b expected 0", instr_valid); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rack_req: got %b expected 1", imem_req); end
    checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL rack_new_addr: got %h expected 200", imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'hE000_0200;
    next_cycle();
    imem_ack = 1'b0;
    checks++; if (instr_pc !== 32'h200) begin errors++; $display("FAIL rack_target_pc: got %h expected 200", instr_pc); end
    checks++; if (instruction !== 32'hE000_0200) begin errors++; $display("FAIL rack_target_instr: got %h expected e0000200", instruction); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_addr [4];
    logic [31:0] exp_p8 [4];
    exp_addr[0] = 32'hFFFF_FFF8; exp_addr[1] = 32'hFFFF_FFFC;
    exp_addr[2] = 32'h0000_0000; exp_addr[3] = 32'h0000_0004;
    exp_p8[0] = 32'h0; exp_p8[1] = 32'h0000_0000;
    exp_p8[2] = 32'h0000_0004; exp_p8[3] = 32'h0000_0008;
    @(negedge clk);
    rst_w = 1'b0; ready_w = 1'b1;
    @(negedge clk);
    rst_w = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (addr_w !== exp_addr[k]) begin errors++; $display("FAIL wrap_addr k=%0d: got %h expected %h", k, addr_w, exp_addr[k]); end
      if (k > 0) begin
        checks++; if (pc_w !== exp_addr[k-1]) begin errors++; $display("FAIL wrap_pc k=%0d: got %h expected %h", k, pc_w, exp_addr[k-1]); end
        checks++; if (pc8_w !== exp_p8[k]) begin errors++; $display("FAIL wrap_pc8 k=%0d: got %h expected %h", k, pc8_w, exp_p8[k]); end
      end
      ack_w = 1'b1; rdata_w = exp_addr[k] | 32'hE000_0000;
      next_cycle();
    end
    ack_w = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    instr_ready = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'hE000_0000;
    next_cycle();
    imem_ack = 1'b0;
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_valid: got %b expected 1", instr_valid); end
    checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL arst_pre_addr: got %h expected 4", imem_addr); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL arst_req: got %b expected 0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b expected 0", instr_valid); end
    checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL arst_instr: got %h expected 0", instruction); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL arst_release_req: got %b expected 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL arst_release_addr: got %h expected 0", imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL arst_release_valid: got %b expected 0", instr_valid); end
    imem_ack = 1'b1; imem_rdata = 32'hE000_0000; instr_ready = 1'b1;
    next_cycle();
    imem_ack = 1'b0;
    checks++; if (instr_pc !== 32'h0 || instr_valid !== 1'b1) begin errors++; $display("FAIL arst_first_fetch: got valid %b pc %h expected 1 0", instr_valid, instr_pc); end
  endtask

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = ARM_NOP; instr_ready = 1'b0;
    redirect = 1'b0; redirect_pc = '0;
    rst_w = 1'b0; ack_w = 1'b0; rdata_w = ARM_NOP; ready_w = 1'b0;
    redirect_w = 1'b0; redirect_pc_w = '0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_drop();
    test_redirect_ack();
    test_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
